// File: rtl/acc_bank_pkg.sv
// Shared opcodes and the signed add/sub helper used by the accumulator bank.
// sat_add works on a fixed wide container; the caller passes the live width w.
package acc_bank_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_CLR  = 3'd4;
    localparam logic [2:0] OP_PUSH = 3'd5;
    localparam logic [2:0] OP_POP  = 3'd6;
    localparam logic [2:0] OP_NOP7 = 3'd7;

    localparam int SAT_MAX_W = 64;

    // Returns {ovf, result}; only result[w-1:0] is meaningful.
    function automatic logic [SAT_MAX_W:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input logic                 sub,
        input logic                 sat,
        input int                   w
    );
        logic signed [SAT_MAX_W+1:0] sa;
        logic signed [SAT_MAX_W+1:0] sb;
        logic signed [SAT_MAX_W+1:0] r;
        logic signed [SAT_MAX_W+1:0] hi;
        logic signed [SAT_MAX_W+1:0] lo;
        logic                        ovf;
        logic [SAT_MAX_W-1:0]        res;
        sa = '0;
        sb = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            sa[i] = (i < w) ? a[i] : a[w-1];
            sb[i] = (i < w) ? b[i] : b[w-1];
        end
        sa[SAT_MAX_W+1:SAT_MAX_W] = {2{a[w-1]}};
        sb[SAT_MAX_W+1:SAT_MAX_W] = {2{b[w-1]}};
        r = sub ? (sa - sb) : (sa + sb);
        hi = '0;
        hi[w-1] = 1'b1;
        hi = hi - 1;
        lo = ~hi;
        ovf = (r > hi) || (r < lo);
        if (ovf && sat) begin
            res = r[SAT_MAX_W+1] ? lo[SAT_MAX_W-1:0] : hi[SAT_MAX_W-1:0];
        end else begin
            res = r[SAT_MAX_W-1:0];
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/acc_lifo.sv
// Context save stack: LIFO of accumulator values with occupancy count.
// The top entry is read combinationally so a POP can write it back on the same edge.
module acc_lifo #(
    parameter int  E_BITS      = 16,
    parameter int  STACK_DEPTH = 4,
    localparam int CNT_W       = $clog2(STACK_DEPTH + 1),
    localparam int AW          = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [E_BITS-1:0] data_i,
    output logic [E_BITS-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o
);

    logic [E_BITS-1:0] mem_q [STACK_DEPTH];
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [AW-1:0]     wr_idx;
    logic [AW-1:0]     top_idx;

    assign full_o  = (count_q == CNT_W'(STACK_DEPTH));
    assign empty_o = (count_q == '0);
    assign err_o   = (push_i && full_o) || (pop_i && empty_o);
    assign wr_idx  = AW'(count_q);
    assign top_idx = empty_o ? '0 : AW'(count_q - CNT_W'(1));
    assign data_o  = mem_q[top_idx];

    always_comb begin
        count_d = count_q;
        if (push_i && !full_o) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_i && !empty_o) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(negedge clk_i) begin
        if (srst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entries are never cleared; the count alone defines what is valid.
    always_ff @(negedge clk_i) begin
        if (!srst_i && push_i && !full_o) begin
            mem_q[wr_idx] <= data_i;
        end
    end

endmodule

// File: rtl/acc_bank.sv
// Multi-bank accumulator with flags, optional signed saturation and a context stack.
// All state changes on the falling edge of i_clock; o_acc is a combinational bank read.
module acc_bank
    import acc_bank_pkg::*;
#(
    parameter int  E_BITS      = 16,
    parameter int  N_BANKS     = 4,
    parameter int  STACK_DEPTH = 4,
    parameter bit  SATURATE    = 1'b0,
    localparam int BANK_W      = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_enable,
    input  logic [2:0]        i_op,
    input  logic [BANK_W-1:0] i_bank,
    input  logic [E_BITS-1:0] i_operand,
    output logic [E_BITS-1:0] o_acc,
    output logic              o_zero,
    output logic              o_neg,
    output logic              o_ovf,
    output logic              o_stack_full,
    output logic              o_stack_empty,
    output logic              o_err
);

    logic [E_BITS-1:0]    bank_q [N_BANKS];
    logic [E_BITS-1:0]    bank_d;
    logic                 bank_we;
    logic                 bank_ok;
    logic [E_BITS-1:0]    bank_rd;
    logic                 zero_q;
    logic                 neg_q;
    logic                 ovf_q;
    logic                 ovf_d;
    logic                 err_q;
    logic                 err_d;
    logic                 flag_we;
    logic                 lifo_push;
    logic                 lifo_pop;
    logic                 lifo_full;
    logic                 lifo_empty;
    logic                 lifo_err;
    logic [E_BITS-1:0]    lifo_rd;
    logic [SAT_MAX_W-1:0] a_w;
    logic [SAT_MAX_W-1:0] b_w;
    logic [SAT_MAX_W:0]   alu;

    // Only reachable when N_BANKS is not a power of two.
    assign bank_ok = (32'(i_bank) < 32'(N_BANKS));
    assign bank_rd = bank_ok ? bank_q[i_bank] : '0;

    assign o_acc         = bank_rd;
    assign o_zero        = zero_q;
    assign o_neg         = neg_q;
    assign o_ovf         = ovf_q;
    assign o_err         = err_q;
    assign o_stack_full  = lifo_full;
    assign o_stack_empty = lifo_empty;

    always_comb begin
        a_w = '0;
        b_w = '0;
        a_w[E_BITS-1:0] = bank_rd;
        b_w[E_BITS-1:0] = i_operand;
        alu = sat_add(a_w, b_w, (i_op == OP_SUB), SATURATE, E_BITS);
    end

    always_comb begin
        bank_we   = 1'b0;
        bank_d    = E_BITS'(alu);
        flag_we   = 1'b0;
        ovf_d     = 1'b0;
        lifo_push = 1'b0;
        lifo_pop  = 1'b0;
        err_d     = 1'b0;
        if (i_enable && (i_op != OP_NOP) && (i_op != OP_NOP7)) begin
            if (!bank_ok) begin
                err_d = 1'b1;
            end else begin
                case (i_op)
                    OP_LOAD: begin
                        bank_we = 1'b1;
                        bank_d  = i_operand;
                        flag_we = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        bank_we = 1'b1;
                        flag_we = 1'b1;
                        ovf_d   = alu[SAT_MAX_W];
                    end
                    OP_CLR: begin
                        bank_we = 1'b1;
                        bank_d  = '0;
                        flag_we = 1'b1;
                    end
                    OP_PUSH: begin
                        lifo_push = 1'b1;
                        err_d     = lifo_err;
                    end
                    OP_POP: begin
                        lifo_pop = 1'b1;
                        err_d    = lifo_err;
                        if (!lifo_empty) begin
                            bank_we = 1'b1;
                            bank_d  = lifo_rd;
                            flag_we = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(negedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < N_BANKS; i++) begin
                bank_q[i] <= '0;
            end
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
            ovf_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (bank_we) begin
                bank_q[i_bank] <= bank_d;
            end
            if (flag_we) begin
                zero_q <= (bank_d == '0);
                neg_q  <= bank_d[E_BITS-1];
                ovf_q  <= ovf_d;
            end
            err_q <= err_d;
        end
    end

    acc_lifo #(
        .E_BITS      (E_BITS),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk_i   (i_clock),
        .srst_i  (i_reset),
        .push_i  (lifo_push),
        .pop_i   (lifo_pop),
        .data_i  (bank_rd),
        .data_o  (lifo_rd),
        .full_o  (lifo_full),
        .empty_o (lifo_empty),
        .err_o   (lifo_err)
    );

endmodule
